// File: rtl/aie_pkg.sv
// Shared types for the AIE ring array: flit opcodes and width helpers.
// Optional build macro AIE_SATURATE_EN selects saturating PE accumulation.
package aie_pkg;

    typedef enum logic [1:0] {
        OP_DATA  = 2'b00,
        OP_COEF  = 2'b01,
        OP_FLUSH = 2'b10,
        OP_CLEAR = 2'b11
    } aie_op_e;

    localparam int OP_W = 2;

    // Rank field must also encode the egress id NUM_TILES
    function automatic int aie_id_w(input int num_tiles);
        return $clog2(num_tiles + 1);
    endfunction

endpackage

// File: rtl/aie_ring_tile.sv
// One ring tile: input FIFO, switch output register and MAC PE.
// AIE_SATURATE_EN makes the PE accumulate with unsigned saturation.
module aie_ring_tile
    import aie_pkg::*;
#(
    parameter int NUM_TILES  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RANK       = 0,
    parameter int IDW        = aie_id_w(NUM_TILES),
    parameter int FW         = OP_W + 2 * IDW + DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [FW-1:0] in_flit_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [FW-1:0] out_flit_o,
    output logic          busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = DATA_WIDTH;

    typedef struct packed {
        aie_op_e          op;
        logic [IDW-1:0]   dest;
        logic [IDW-1:0]   src;
        logic [DW-1:0]    data;
    } flit_t;

    flit_t         mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    flit_t         sw_q, sw_d;
    logic          sw_vld_q, sw_vld_d;
    logic          rr_q, rr_d;
    logic [DW-1:0] coef_q, coef_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] res_q, res_d;
    logic          pend_q, pend_d;

    flit_t in_f, head, inj_f;
    logic  push, pop, head_vld, local_hit, fwd_req;
    logic  sw_free, fwd_gnt, inj_gnt, pe_pop;

    function automatic logic [DW-1:0] mac(
        input logic [DW-1:0] a,
        input logic [DW-1:0] c,
        input logic [DW-1:0] d
    );
`ifdef AIE_SATURATE_EN
        logic [2*DW-1:0] p;
        logic [DW-1:0]   pc;
        logic [DW:0]     s;
        p  = {{DW{1'b0}}, c} * {{DW{1'b0}}, d};
        pc = (|p[2*DW-1:DW]) ? '1 : p[DW-1:0];
        s  = {1'b0, a} + {1'b0, pc};
        return s[DW] ? '1 : s[DW-1:0];
`else
        return a + c * d;
`endif
    endfunction

    assign in_f       = in_flit_i;
    assign in_ready_o = (cnt_q != CW'(FIFO_DEPTH));
    assign push       = in_valid_i && in_ready_o;
    assign head       = mem_q[rd_q];
    assign head_vld   = (cnt_q != '0);
    assign local_hit  = head_vld && (head.dest == IDW'(RANK));
    assign fwd_req    = head_vld && !local_hit;
    assign sw_free    = !sw_vld_q || out_ready_i;
    assign fwd_gnt    = sw_free && fwd_req && !(pend_q && rr_q);
    assign inj_gnt    = sw_free && pend_q && !(fwd_req && !rr_q);
    assign pe_pop     = local_hit &&
                        (head.op != OP_FLUSH || !pend_q || inj_gnt);
    assign pop        = fwd_gnt || pe_pop;
    assign cnt_d      = cnt_q + CW'(push) - CW'(pop);

    assign inj_f = '{op: OP_DATA, dest: IDW'(NUM_TILES),
                     src: IDW'(RANK), data: res_q};

    // FIFO payload; occupancy count qualifies it, so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_f;
    end

    // Switch register load: forward vs injection, RR on contention
    always_comb begin
        sw_vld_d = sw_vld_q && !out_ready_i;
        sw_d     = sw_q;
        rr_d     = rr_q;
        unique case (1'b1)
            fwd_gnt: begin
                sw_vld_d = 1'b1;
                sw_d     = head;
            end
            inj_gnt: begin
                sw_vld_d = 1'b1;
                sw_d     = inj_f;
            end
            default: ;
        endcase
        if (sw_free && fwd_req && pend_q) rr_d = !rr_q;
    end

    // PE next state; pending clears on grant before a new FLUSH lands
    always_comb begin
        coef_d = coef_q;
        acc_d  = acc_q;
        res_d  = res_q;
        pend_d = pend_q && !inj_gnt;
        if (pe_pop) begin
            unique case (head.op)
                OP_COEF:  coef_d = head.data;
                OP_DATA:  acc_d  = mac(acc_q, coef_q, head.data);
                OP_CLEAR: acc_d  = '0;
                OP_FLUSH: begin
                    res_d  = acc_q;
                    pend_d = 1'b1;
                    acc_d  = '0;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            sw_q     <= '0;
            sw_vld_q <= 1'b0;
            rr_q     <= 1'b0;
            coef_q   <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            cnt_q    <= cnt_d;
            sw_q     <= sw_d;
            sw_vld_q <= sw_vld_d;
            rr_q     <= rr_d;
            coef_q   <= coef_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            pend_q   <= pend_d;
        end
    end

    assign out_valid_o = sw_vld_q;
    assign out_flit_o  = sw_q;
    assign busy_o      = head_vld || sw_vld_q || pend_q;

endmodule

// File: rtl/aie_ring_array.sv
// Unidirectional ring of MAC tiles with host ingress at tile 0 and
// egress from the last tile. AIE_SATURATE_EN selects saturating MACs.
module aie_ring_array
    import aie_pkg::*;
#(
    parameter int NUM_TILES  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int DW_ID     = aie_id_w(NUM_TILES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DW_ID-1:0]      in_dest,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW_ID-1:0]      out_src,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);
    localparam int FW = OP_W + 2 * DW_ID + DATA_WIDTH;

    logic [FW-1:0]          link_flit [NUM_TILES+1];
    logic [NUM_TILES:0]     link_vld;
    logic [NUM_TILES:0]     link_rdy;
    logic [NUM_TILES-1:0]   tile_busy;
    logic [OP_W+DW_ID-1:0]  unused_eg;

    assign link_vld[0]  = in_valid;
    assign link_flit[0] = {in_op, in_dest, DW_ID'(NUM_TILES), in_data};
    assign in_ready     = link_rdy[0] && rst_n;

    for (genvar k = 0; k < NUM_TILES; k++) begin : g_tile
        aie_ring_tile #(
            .NUM_TILES  (NUM_TILES),
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .RANK       (k)
        ) u_tile (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (link_vld[k]),
            .in_ready_o  (link_rdy[k]),
            .in_flit_i   (link_flit[k]),
            .out_valid_o (link_vld[k+1]),
            .out_ready_i (link_rdy[k+1]),
            .out_flit_o  (link_flit[k+1]),
            .busy_o      (tile_busy[k])
        );
    end

    assign link_rdy[NUM_TILES] = out_ready;
    assign out_valid = link_vld[NUM_TILES];
    assign out_data  = link_flit[NUM_TILES][DATA_WIDTH-1:0];
    assign out_src   = link_flit[NUM_TILES][DATA_WIDTH +: DW_ID];
    assign unused_eg = link_flit[NUM_TILES][FW-1 -: OP_W+DW_ID];
    assign busy      = |tile_busy;

endmodule

// File: tb/tb_aie_ring_array.sv
// Scoreboard bench for aie_ring_array at N=4, DW=8, DEPTH=4.
module tb_aie_ring_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [1:0] in_op;
    logic [2:0] in_dest;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [2:0] out_src;
    logic [7:0] out_data;
    logic       busy;

`ifdef AIE_SATURATE_EN
    localparam logic [7:0] WRAP_EXP = 8'hFF;
`else
    localparam logic [7:0] WRAP_EXP = 8'h00;
`endif

    int          errors = 0;
    int          checks = 0;
    int          rx_cnt = 0;
    logic [10:0] exp_q[$];
    bit          res_wait = 0;
    logic [2:0]  res_src;
    logic [7:0]  res_exp;
    int          res_pos = 99;

    aie_ring_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // egress scoreboard: a transfer happens on the next rising edge
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (res_wait && out_src == res_src) begin
                if (out_data !== res_exp) begin
                    errors++;
                    $display("FAIL result_data: got %h required %h",
                             out_data, res_exp);
                end
                res_wait = 0;
                res_pos  = rx_cnt;
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL egress_unexpected: got src=%0d data=%h required none",
                         out_src, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_src, out_data} !== e) begin
                    errors++;
                    $display("FAIL egress_flit: got src=%0d data=%h required src=%0d data=%h",
                             out_src, out_data, e[10:8], e[7:0]);
                end
            end
            rx_cnt++;
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] dest,
                        input logic [7:0] data);
        bit ok = 0;
        in_op    = op;
        in_dest  = dest;
        in_data  = data;
        in_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready required accept");
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 400 && (exp_q.size() != 0 || res_wait || busy); n++)
            @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_dest = 3'd0; in_data = 8'h00; out_ready = 1'b1;
        #2;
        checks += 5;
        if (in_ready !== 1'b0) begin errors++;
            $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (out_src !== 3'd0) begin errors++;
            $display("FAIL rst_out_src: got %0d required 0", out_src); end
        if (out_data !== 8'h00) begin errors++;
            $display("FAIL rst_out_data: got %h required 00", out_data); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %b required 0", busy); end
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL post_rst_busy: got %b required 0", busy); end
    endtask

    task automatic test_bypass();
        int lat = 0;
        out_ready = 1'b1;
        exp_q.push_back({3'd4, 8'hA5});
        send(2'b00, 3'd4, 8'hA5);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        checks += 3;
        if (lat !== 7) begin errors++;
            $display("FAIL bypass_latency: got %0d required 7", lat); end
        if (out_data !== 8'hA5) begin errors++;
            $display("FAIL bypass_data: got %h required a5", out_data); end
        if (out_src !== 3'd4) begin errors++;
            $display("FAIL bypass_src: got %0d required 4", out_src); end
        wait_drain();
    endtask

    task automatic test_mac();
        send(2'b01, 3'd1, 8'd3);
        send(2'b00, 3'd1, 8'd5);
        send(2'b00, 3'd1, 8'd7);
        exp_q.push_back({3'd1, 8'h24});
        send(2'b10, 3'd1, 8'h00);
        exp_q.push_back({3'd1, 8'h00});
        send(2'b10, 3'd1, 8'h00);
        wait_drain();
        checks++;
        if (exp_q.size() !== 0 || busy !== 1'b0) begin errors++;
            $display("FAIL mac_drain: got left=%0d busy=%b required 0 0",
                     exp_q.size(), busy); end
    endtask

    task automatic test_wrap();
        send(2'b01, 3'd2, 8'h10);
        send(2'b00, 3'd2, 8'h20);
        exp_q.push_back({3'd2, WRAP_EXP});
        send(2'b10, 3'd2, 8'h00);
        wait_drain();
        checks++;
        if (exp_q.size() !== 0) begin errors++;
            $display("FAIL wrap_drain: got left=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        bit acc;
        out_ready = 1'b0;
        in_op = 2'b00; in_dest = 3'd4; in_data = 8'd0; in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acc = in_ready && in_valid;
            if (acc) exp_q.push_back({3'd4, in_data});
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                in_data = 8'(idx);
                if (idx == 25) in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks += 2;
        if (idx !== 20) begin errors++;
            $display("FAIL bp_accepted: got %0d required 20", idx); end
        if (in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && idx < 25; c++) begin
            @(negedge clk);
            acc = in_ready && in_valid;
            if (acc) exp_q.push_back({3'd4, in_data});
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                in_data = 8'(idx);
                if (idx == 25) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        wait_drain();
        checks += 2;
        if (idx !== 25) begin errors++;
            $display("FAIL bp_total: got %0d required 25", idx); end
        if (exp_q.size() !== 0 || busy !== 1'b0) begin errors++;
            $display("FAIL bp_drain: got left=%0d busy=%b required 0 0",
                     exp_q.size(), busy); end
    endtask

    task automatic test_contention();
        int start;
        out_ready = 1'b1;
        send(2'b01, 3'd0, 8'd2);
        send(2'b00, 3'd0, 8'd9);
        res_src  = 3'd0;
        res_exp  = 8'h12;
        res_pos  = 99;
        res_wait = 1;
        start    = rx_cnt;
        send(2'b10, 3'd0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({3'd4, 8'h40 + 8'(i)});
            send(2'b00, 3'd4, 8'h40 + 8'(i));
        end
        wait_drain();
        checks += 3;
        if (res_wait !== 1'b0) begin errors++;
            $display("FAIL cont_result_seen: got none required src 0"); end
        if (res_pos - start > 1) begin errors++;
            $display("FAIL cont_position: got %0d required <=1",
                     res_pos - start); end
        if (exp_q.size() !== 0) begin errors++;
            $display("FAIL cont_drain: got left=%0d required 0", exp_q.size()); end
        res_wait = 0;
    endtask

    task automatic test_reset_mid();
        int rx0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(2'b00, 3'd4, 8'h80 + 8'(i));
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b1) begin errors++;
            $display("FAIL mid_inflight: got out_valid=%b required 1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL mid_async_valid: got %b required 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++;
            $display("FAIL mid_in_ready: got %b required 0", in_ready); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL mid_busy: got %b required 0", busy); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++;
            $display("FAIL mid_post_busy: got %b required 0", busy); end
        out_ready = 1'b1;
        rx0 = rx_cnt;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (rx_cnt !== rx0) begin errors++;
            $display("FAIL mid_stale: got %0d flits required 0", rx_cnt - rx0); end
        exp_q.push_back({3'd4, 8'h3C});
        send(2'b00, 3'd4, 8'h3C);
        wait_drain();
        checks++;
        if (exp_q.size() !== 0) begin errors++;
            $display("FAIL mid_fresh: got left=%0d required 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_mac();
        test_wrap();
        test_backpressure();
        test_contention();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
